// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant ownership.
// A requester that wins keeps the grant while it holds its request. The
// grant rotates fairly by a circular pointer. An owner that has held the
// grant for MAX_HOLD cycles while someone else waits is preempted.
//
// Request/grant handshake: req[i] is a level. A grant is only issued or kept
// on an edge where req[i] was sampled high. The owner gives up the grant by
// dropping req. The grant is then gone or handed over at the very next edge.
//
// Every output comes from a flop. No path runs from req to an output.
// dbg_state shows the FSM state (0 = IDLE, 1 = GRANT) so checkers can bind to it.
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [0:N-1]   req,
  output logic [0:N-1]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt,
  output logic [7:0]     hold_cnt,
  output logic           dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam bit       PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_SAT   = 8'hFF;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [0:N-1]   r_gnt;
  logic [0:N-1]   w_gnt_nxt;
  logic           r_valid;
  logic           w_valid_nxt;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_id_nxt;
  logic [7:0]     r_hold;
  logic [7:0]     w_hold_nxt;
  logic           r_preempt;
  logic           w_preempt_nxt;

  logic [0:N-1]   w_cand;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_win_inc;
  logic           w_owner_req;
  logic           w_timeout;

  // Candidates: every requester, except the current owner while a grant is held.
  always_comb begin
    w_cand = req;
    if (r_state == ST_GRANT) begin
      w_cand[r_id] = 1'b0;
    end
  end

  // Circular first-set search from r_ptr. While a grant is held, r_ptr always
  // equals owner+1 (mod N), so this is the search "from o+1" for a handoff.
  // The loop runs from the far end back toward r_ptr. The last match written
  // is therefore the first one in circular order.
  always_comb begin
    logic [IDW-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % N);
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // The pointer moves to one past the winner and wraps from N-1 to 0.
  always_comb begin
    if (int'(w_win) == N - 1) begin
      w_win_inc = '0;
    end else begin
      w_win_inc = w_win + IDW'(1);
    end
  end

  assign w_owner_req = req[r_id];
  assign w_timeout   = PREEMPT_EN && (r_hold >= MAX_HOLD_L) && w_found;

  // Next-state and next-output decision, one branch per case.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_valid_nxt   = r_valid;
    w_id_nxt      = r_id;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt       = ST_GRANT;
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_win]  = 1'b1;
          w_valid_nxt       = 1'b1;
          w_id_nxt          = w_win;
          w_hold_nxt        = 8'd1;
          w_ptr_nxt         = w_win_inc;
        end
      end

      ST_GRANT: begin
        if (!w_owner_req) begin
          // The owner released. Hand over with no gap if anyone else waits.
          if (w_found) begin
            w_gnt_nxt        = '0;
            w_gnt_nxt[w_win] = 1'b1;
            w_valid_nxt      = 1'b1;
            w_id_nxt         = w_win;
            w_hold_nxt       = 8'd1;
            w_ptr_nxt        = w_win_inc;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_id_nxt    = '0;
            w_hold_nxt  = 8'd0;
          end
        end else if (w_timeout) begin
          // The owner held the grant too long while others wait. It loses
          // the grant now and competes again normally afterwards.
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_valid_nxt      = 1'b1;
          w_id_nxt         = w_win;
          w_hold_nxt       = 8'd1;
          w_ptr_nxt        = w_win_inc;
          w_preempt_nxt    = 1'b1;
        end else begin
          // The owner keeps the grant. A lone owner always ends up here.
          if (r_hold != HOLD_SAT) begin
            w_hold_nxt = r_hold + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_id_nxt    = '0;
        w_hold_nxt  = 8'd0;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // State and output registers. Reset drops the grant with no handoff.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_hold    <= 8'd0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_id      <= w_id_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_id;
  assign preempt   = r_preempt;
  assign hold_cnt  = r_hold;
  assign dbg_state = r_state;

  // Structural invariants of the registered grant.
  a_gnt_onehot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(r_gnt));
  a_valid_is_or : assert property (@(posedge clock) disable iff (reset)
    r_valid == (|r_gnt));
  a_id_zero_idle : assert property (@(posedge clock) disable iff (reset)
    !r_valid |-> (r_id == '0));
  a_next_gnt_requested : assert property (@(posedge clock) disable iff (reset)
    (|w_gnt_nxt) |-> (|(w_gnt_nxt & req)));

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter. It uses N=8 and two instances on the
// same req. dut_a has MAX_HOLD=4 and dut_b has MAX_HOLD=0 (preemption off).
module tb_rr_hold_arbiter;

  localparam int N   = 8;
  localparam int IDW = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [0:N-1] req = '0;

  always #5 clock = ~clock;

  logic [0:N-1]   a_gnt, b_gnt;
  logic           a_valid, b_valid;
  logic [IDW-1:0] a_id, b_id;
  logic           a_pre, b_pre;
  logic [7:0]     a_hold, b_hold;
  logic           a_dbg, b_dbg;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(4)) dut_a (
    .clock(clock), .reset(reset), .req(req),
    .gnt(a_gnt), .gnt_valid(a_valid), .gnt_id(a_id),
    .preempt(a_pre), .hold_cnt(a_hold), .dbg_state(a_dbg)
  );

  rr_hold_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (
    .clock(clock), .reset(reset), .req(req),
    .gnt(b_gnt), .gnt_valid(b_valid), .gnt_id(b_id),
    .preempt(b_pre), .hold_cnt(b_hold), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [IDW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:N-1] oh(input int i);
    logic [0:N-1] r;
    r = '0;
    r[i[2:0]] = 1'b1;
    return r;
  endfunction

  // e = expected owner index, or -1 for no grant.
  task automatic check_dut(input string tag,
                           input logic [0:N-1] g, input logic v, input logic [IDW-1:0] id,
                           input logic [7:0] h, input logic p,
                           input int e, input int exp_h, input int exp_p);
    check({tag, ".gnt"},     32'(g),  (e < 0) ? 32'd0 : 32'(oh(e)));
    check({tag, ".valid"},   32'(v),  (e < 0) ? 32'd0 : 32'd1);
    check({tag, ".id"},      32'(id), (e < 0) ? 32'd0 : 32'(e));
    check({tag, ".hold"},    32'(h),  32'(exp_h));
    check({tag, ".preempt"}, 32'(p),  32'(exp_p));
  endtask

  task automatic chk_a(input string tag, input int e, input int exp_h, input int exp_p);
    check_dut({"a.", tag}, a_gnt, a_valid, a_id, a_hold, a_pre, e, exp_h, exp_p);
  endtask

  task automatic chk_b(input string tag, input int e, input int exp_h, input int exp_p);
    check_dut({"b.", tag}, b_gnt, b_valid, b_id, b_hold, b_pre, e, exp_h, exp_p);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Safety net in case the bench stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int prev;
    int e;
    logic any_pre;
    logic gnt_moved;

    // Reset state.
    reset = 1'b1;
    req   = '0;
    step();
    step();
    chk_a("rst", -1, 0, 0);
    chk_b("rst", -1, 0, 0);
    check("rst.state", 32'(a_dbg), 32'd0);
    reset = 1'b0;

    // Single requester 0: one-cycle latency, then release to idle.
    req = oh(0);
    step();
    chk_a("t1.grant", 0, 1, 0);
    check("t1.state", 32'(a_dbg), 32'd1);
    step();
    step();
    chk_a("t1.hold3", 0, 3, 0);
    req = '0;
    step();
    chk_a("t1.release", -1, 0, 0);
    check("t1.state_idle", 32'(a_dbg), 32'd0);

    // Round robin over 0,3,5 with MAX_HOLD=0. Each owner releases after
    // two grant cycles and requests again one cycle later.
    do_reset();
    req = oh(0) | oh(3) | oh(5);
    exp_q.push_back(3'd0); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    exp_q.push_back(3'd0); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    prev = -1;
    while (exp_q.size() != 0) begin
      e = int'(exp_q.pop_front());
      step();
      chk_b($sformatf("t2.g%0d.first", e), e, 1, 0);
      check("t2.a_preempt", 32'(a_pre), 32'd0);
      if (prev >= 0) req[prev] = 1'b1;
      step();
      chk_b($sformatf("t2.g%0d.second", e), e, 2, 0);
      req[e] = 1'b0;
      prev = e;
    end
    req = '0;
    step();
    chk_b("t2.idle", -1, 0, 0);

    // Preemption with MAX_HOLD=4: owner 2 is preempted by 6, then gets the
    // grant back when 6 releases.
    do_reset();
    req = oh(2);
    step();
    chk_a("t3.h1", 2, 1, 0);
    step();
    chk_a("t3.h2", 2, 2, 0);
    req[6] = 1'b1;
    step();
    chk_a("t3.h3", 2, 3, 0);
    step();
    chk_a("t3.h4", 2, 4, 0);
    step();
    chk_a("t3.preempt", 6, 1, 1);
    chk_b("t3.no_preempt", 2, 5, 0);
    step();
    chk_a("t3.pulse_end", 6, 2, 0);
    req[6] = 1'b0;
    step();
    chk_a("t3.return", 2, 1, 0);

    // Lone owner 7 for 300 cycles: never preempted, hold_cnt saturates.
    do_reset();
    req = oh(7);
    any_pre = 1'b0;
    gnt_moved = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      any_pre = any_pre | a_pre;
      if (a_gnt !== oh(7)) gnt_moved = 1'b1;
      if (k == 1)   chk_a("t4.first", 7, 1, 0);
      if (k == 254) check("t4.hold254", 32'(a_hold), 32'd254);
      if (k == 255) check("t4.hold255", 32'(a_hold), 32'd255);
      if (k == 300) chk_a("t4.sat", 7, 255, 0);
    end
    check("t4.preempt_seen", 32'(any_pre), 32'd0);
    check("t4.gnt_moved", 32'(gnt_moved), 32'd0);

    // Wrap-around: 7 releases while 1 and 6 request. The search starts at 0
    // and picks 1, so ptr becomes 2. From ptr=2, 6 comes before 0.
    req = oh(1) | oh(6);
    step();
    chk_a("t5.wrap", 1, 1, 0);
    req = oh(0) | oh(6);
    step();
    chk_a("t5.ptr2", 6, 1, 0);
    req = '0;
    step();
    chk_a("t5.idle", -1, 0, 0);

    // Reset in the middle of a grant, with all requests high.
    do_reset();
    req = oh(4);
    step();
    chk_a("t6.own4", 4, 1, 0);
    req = '1;
    step();
    chk_a("t6.keep4", 4, 2, 0);
    reset = 1'b1;
    step();
    chk_a("t6.rst", -1, 0, 0);
    chk_b("t6.rst", -1, 0, 0);
    step();
    chk_a("t6.rst_hold", -1, 0, 0);
    reset = 1'b0;
    step();
    chk_a("t6.first", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
